gobou_mac: RTL and testbench
============================

GOBOU_MAC -- requirements
Module: gobou_mac

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width of pixel, weight and result.
REQ-002 SHALL have parameter FRACWIDTH, default 8, number of fractional bits in fixed-point operands.
REQ-003 SHALL have parameter LWIDTH, default 16, width of term-count input.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port xrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mac_start  input  1  one-cycle pulse to begin one dot product.
REQ-007 SHALL have port in_len  input  LWIDTH  number of terms, sampled on accepted mac_start.
REQ-008 SHALL have port in_valid  input  1  pixel_in/weight_in valid.
REQ-009 SHALL have port pixel_in  input  DWIDTH  signed input activation.
REQ-010 SHALL have port weight_in  input  DWIDTH  signed weight.
REQ-011 SHALL have port in_ready  output  1  high only in ACC; a term is accepted on an edge where in_valid && in_ready.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port pixel_out  output  DWIDTH  signed result; feeds the bias stage pixel_in.
REQ-014 SHALL have port out_en  output  1  one-cycle pulse marking pixel_out valid; feeds the bias stage out_en.

Function
REQ-015 SHALL implement states IDLE, ACC, DRAIN, DONE.
REQ-016 IDLE: mac_start with in_len != 0 -> ACC, clear accumulator, load remaining-count register with in_len.
REQ-017 IDLE: mac_start with in_len == 0 -> DONE with accumulator cleared.
REQ-018 ACC: each accepted term decrements the count; acceptance of the last term -> DRAIN.
REQ-019 DRAIN: lasts exactly one cycle, then -> DONE.
REQ-020 DONE: registers pixel_out, pulses out_en for one cycle, then -> IDLE.
REQ-021 mac_start outside IDLE SHALL be ignored; in_valid outside ACC SHALL be ignored.
REQ-022 Stage 1 SHALL register the full 2*DWIDTH signed product of each accepted term on its acceptance edge E.
REQ-023 Stage 2 SHALL add that product into a 2*DWIDTH+8-bit signed accumulator on edge E+1.
REQ-024 For the last term accepted on edge E, pixel_out and out_en SHALL update on edge E+2; out_en high for exactly one cycle.
REQ-025 For in_len == 0 with mac_start on edge S, pixel_out = 0 and out_en SHALL be high for one cycle after edge S+1.
REQ-026 Scaling SHALL be an arithmetic right shift of the accumulator by FRACWIDTH (floor toward minus infinity, no rounding).
REQ-027 pixel_out SHALL hold its value between out_en pulses.
REQ-028 Back-to-back: mac_start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-029 xrst low SHALL asynchronously force IDLE and clear count, product, accumulator and pixel_out to 0, and in_ready, busy and out_en to 0.
REQ-030 Reset mid-operation SHALL abandon the dot product with no out_en pulse; operation resumes on the first edge after xrst deasserts.

Configuration
REQ-031 Macro GOBOU_MAC_SAT_EN defined: the shifted result SHALL saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
REQ-032 Macro GOBOU_MAC_SAT_EN undefined: the shifted result SHALL be truncated to its low DWIDTH bits (two's-complement wrap).

Verification (DWIDTH=16, FRACWIDTH=8)
REQ-033 in_len=3, three terms (256,256) back-to-back -> one out_en pulse two edges after the last acceptance; pixel_out=768.
REQ-034 in_len=2, terms (-256,256) then (1,1) with in_valid gap of 2 cycles -> pixel_out=-256 (floor of -65535/256); in_ready low throughout DRAIN and DONE.
REQ-035 in_len=4, four terms (32767,32767) -> pixel_out=32767 with GOBOU_MAC_SAT_EN; pixel_out=-1024 (0xFC00) without.
REQ-036 in_len=0 -> pixel_out=0, single out_en pulse; a second mac_start during busy produces no extra pulse.
REQ-037 in_len=5, xrst pulsed low after 2 terms -> all outputs 0 immediately, no out_en; a new in_len=1 run with (512,512) -> pixel_out=1024.

Source files
------------

// File: rtl/gobou_mac.sv
// Multi-cycle signed fixed-point dot-product MAC: registered product, wide accumulator, shift-scaled result.
// Optional GOBOU_MAC_SAT_EN saturates the scaled result; otherwise it wraps to DWIDTH bits.
module gobou_mac #(
   parameter int DWIDTH    = 16,
   parameter int FRACWIDTH = 8,
   parameter int LWIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     mac_start,
   input  logic        [LWIDTH-1:0] in_len,
   input  logic                     in_valid,
   input  logic signed [DWIDTH-1:0] pixel_in,
   input  logic signed [DWIDTH-1:0] weight_in,
   output logic                     in_ready,
   output logic                     busy,
   output logic signed [DWIDTH-1:0] pixel_out,
   output logic                     out_en
);

   localparam int PW = 2 * DWIDTH;
   localparam int AW = PW + 8;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

   state_t                  state;
   logic       [LWIDTH-1:0] count;
   logic signed [PW-1:0]    prod_p1;
   logic                    vld_p1;
   logic signed [AW-1:0]    acc_p2;
   logic                    accept;
   logic                    start;

`ifdef GOBOU_MAC_SAT_EN
   localparam logic signed [AW-1:0] SAT_MAX = $signed({{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}});
   localparam logic signed [AW-1:0] SAT_MIN = $signed({{(AW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}});
`endif

   // Arithmetic shift floors toward minus infinity; no rounding term is added.
   function automatic logic signed [DWIDTH-1:0] scale(input logic signed [AW-1:0] a);
`ifdef GOBOU_MAC_SAT_EN
      logic signed [AW-1:0] s;
      s = a >>> FRACWIDTH;
      if (s > SAT_MAX)
         return SAT_MAX[DWIDTH-1:0];
      else if (s < SAT_MIN)
         return SAT_MIN[DWIDTH-1:0];
      else
         return s[DWIDTH-1:0];
`else
      return DWIDTH'(a >>> FRACWIDTH);
`endif
   endfunction

   assign accept   = in_valid && (state == ACC);
   assign start    = mac_start && (state == IDLE);
   assign in_ready = (state == ACC);
   assign busy     = (state != IDLE);

   // Stage 1: product of each accepted term
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         prod_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= accept;
         if (accept)
            prod_p1 <= pixel_in * weight_in;
      end
   end

   // Stage 2: accumulate; a start can never coincide with a pending product
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         acc_p2 <= '0;
      end else if (start) begin
         acc_p2 <= '0;
      end else if (vld_p1) begin
         acc_p2 <= acc_p2 + AW'(prod_p1);
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state     <= IDLE;
         count     <= '0;
         pixel_out <= '0;
         out_en    <= 1'b0;
      end else begin
         out_en <= 1'b0;
         case (state)
            IDLE: begin
               if (mac_start) begin
                  count <= in_len;
                  state <= (in_len == '0) ? DONE : ACC;
               end
            end
            ACC: begin
               if (in_valid) begin
                  count <= count - LWIDTH'(1);
                  if (count == LWIDTH'(1))
                     state <= DRAIN;
               end
            end
            DRAIN: state <= DONE;
            DONE: begin
               pixel_out <= scale(acc_p2);
               out_en    <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gobou_mac.sv
// Directed-vector bench for gobou_mac (DWIDTH=16, FRACWIDTH=8).
module tb_gobou_mac;

   logic               clk;
   logic               xrst;
   logic               mac_start;
   logic        [15:0] in_len;
   logic               in_valid;
   logic signed [15:0] pixel_in;
   logic signed [15:0] weight_in;
   logic               in_ready;
   logic               busy;
   logic signed [15:0] pixel_out;
   logic               out_en;

   int checks = 0;
   int errors = 0;
   int pulses;
   int lat;

   gobou_mac dut (
      .clk       (clk),
      .xrst      (xrst),
      .mac_start (mac_start),
      .in_len    (in_len),
      .in_valid  (in_valid),
      .pixel_in  (pixel_in),
      .weight_in (weight_in),
      .in_ready  (in_ready),
      .busy      (busy),
      .pixel_out (pixel_out),
      .out_en    (out_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      mac_start = 1'b1;
      in_len    = 16'(len);
      tick();
      mac_start = 1'b0;
   endtask

   task automatic feed(input int p, input int w);
      in_valid  = 1'b1;
      pixel_in  = 16'(p);
      weight_in = 16'(w);
      tick();
      in_valid  = 1'b0;
   endtask

   // Leaves the bench in the cycle where out_en is high.
   task automatic wait_out(input string tag, input int exp_val, input int exp_lat);
      int cyc;
      cyc = 0;
      while (out_en !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_lat"}, cyc, exp_lat);
      check({tag, "_val"}, pixel_out, exp_val);
   endtask

   initial begin
      xrst = 1'b0; mac_start = 1'b0; in_len = '0;
      in_valid = 1'b0; pixel_in = '0; weight_in = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_out_en", out_en, 0);
      check("rst_pixel", pixel_out, 0);
      xrst = 1'b1;
      tick();

      // three equal terms back-to-back
      do_start(3);
      check("t1_ready", in_ready, 1);
      check("t1_busy", busy, 1);
      feed(256, 256);
      feed(256, 256);
      feed(256, 256);
      wait_out("t1", 768, 2);
      tick();
      check("t1_single", out_en, 0);
      check("t1_idle", busy, 0);

      // negative sum with input gap, junk offered during DRAIN/DONE
      do_start(2);
      feed(-256, 256);
      tick();
      tick();
      feed(1, 1);
      in_valid = 1'b1; pixel_in = 16'sd100; weight_in = 16'sd100;
      check("t2_drain_ready", in_ready, 0);
      check("t2_drain_busy", busy, 1);
      tick();
      check("t2_done_ready", in_ready, 0);
      check("t2_done_busy", busy, 1);
      tick();
      in_valid = 1'b0;
      check("t2_out_en", out_en, 1);
      check("t2_val", pixel_out, -256);
      tick();

      // overflow: saturate or wrap
      do_start(4);
      repeat (4) feed(32767, 32767);
`ifdef GOBOU_MAC_SAT_EN
      wait_out("t3", 32767, 2);
`else
      wait_out("t3", -1024, 2);
`endif

      // zero-length run started in the IDLE cycle right after DONE
      do_start(0);
      check("t3_single", out_en, 0);
      check("t4_busy", busy, 1);
      mac_start = 1'b1; in_len = 16'd2;
      tick();
      mac_start = 1'b0; in_len = '0;
      check("t4_out_en", out_en, 1);
      check("t4_val", pixel_out, 0);
      pulses = 0;
      repeat (4) begin
         tick();
         if (out_en) pulses++;
      end
      check("t4_extra_pulse", pulses, 0);
      check("t4_idle", busy, 0);

      // reset mid-run, then a fresh run
      do_start(5);
      feed(100, 100);
      feed(100, 100);
      xrst = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ready", in_ready, 0);
      check("t5_rst_out_en", out_en, 0);
      check("t5_rst_pixel", pixel_out, 0);
      tick();
      xrst = 1'b1;
      pulses = 0;
      repeat (4) begin
         tick();
         if (out_en) pulses++;
      end
      check("t5_no_pulse", pulses, 0);
      do_start(1);
      feed(512, 512);
      wait_out("t5", 1024, 2);
      tick();
      tick();
      check("t5_hold", pixel_out, 1024);
      check("t5_single", out_en, 0);

      lat = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
